// File: rtl/mem_readout_sched_pkg.sv
// ============================================================================
// mem_readout_sched_pkg : port/select constants, port-to-select code table and
//                         readout FSM state type, shared with the stream mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_readout_sched_pkg;

    localparam int NPORTS = 12;
    localparam int CNT_W  = 6;

    localparam logic [3:0] SEL_HEADER = 4'b1111;
    localparam logic [3:0] SEL_IDLE   = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_READ   = 2'd2
    } state_t;

    // Codes 1010 and 1110 are skipped so ports 09..11 land on 1011..1101.
    function automatic logic [3:0] sel_code(input logic [3:0] port);
        sel_code = (port < 4'd9) ? (port + 4'd1) : (port + 4'd2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_readout_sched_prio.sv
// ============================================================================
// prio_enc12 : combinational 12-input priority encoder, lowest index wins.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prio_enc12 (
    input  logic [11:0] req_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o   = 4'd0;
        valid_o = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_readout_sched.sv
// ============================================================================
// mem_readout_sched : per-BX readout scheduler for the 12-port stream mux;
//                     header slot, then gap-free reads under a word budget.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_readout_sched
    import mem_readout_sched_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int WORD_BUDGET = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              rd_bx,
    input  logic [NPORTS*CNT_W-1:0] nentries,
    output logic [NPORTS-1:0]       rd_en,
    output logic [3+CNT_W-1:0]      rd_add,
    output logic [3:0]              sel_out,
    output logic [2:0]              bx_out,
    output logic                    busy,
    output logic                    done,
    output logic                    truncated
);

    localparam int              WC_W   = $clog2(WORD_BUDGET + 1);
    localparam logic [WC_W-1:0] BUDGET = WC_W'(WORD_BUDGET);

    state_t                         state_q, state_d;
    logic [NPORTS-1:0][CNT_W-1:0]   rem_q, rem_d;
    logic [NPORTS-1:0][CNT_W-1:0]   idx_q, idx_d;
    logic [2:0]                     bx_q, bx_d;
    logic [WC_W-1:0]                wcnt_q, wcnt_d;
    logic                           done_q, done_d;
    logic                           trunc_q, trunc_d;
    logic [RD_LAT-1:0][6:0]         pipe_q;

    logic [NPORTS-1:0]              req, last, grant;
    logic [3:0]                     enc_idx;
    logic                           enc_valid;
    logic [CNT_W-1:0]               idx_mux;
    logic [3:0]                     sel_pre;
    logic [2:0]                     bx_pre;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            req[i]  = (rem_q[i] != '0);
            last[i] = (rem_q[i] == CNT_W'(1));
        end
    end

    prio_enc12 u_prio (
        .req_i   (req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign grant = enc_valid ? (NPORTS'(1) << enc_idx) : '0;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        bx_d    = bx_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        trunc_d = 1'b0;
        rd_en   = '0;
        rd_add  = '0;
        sel_pre = SEL_IDLE;
        bx_pre  = '0;
        idx_mux = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) idx_mux = idx_q[i];
        end

        unique case (state_q)
            ST_IDLE: ;
            ST_HEADER: begin
                sel_pre = SEL_HEADER;
                bx_pre  = bx_q;
                wcnt_d  = WC_W'(1);
                if (req == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (wcnt_d >= BUDGET) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    trunc_d = 1'b1;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (enc_valid) begin
                    rd_en   = grant;
                    rd_add  = {bx_q, idx_mux};
                    sel_pre = sel_code(enc_idx);
                    bx_pre  = bx_q;
                    wcnt_d  = wcnt_q + WC_W'(1);
                    for (int i = 0; i < NPORTS; i++) begin
                        if (grant[i]) begin
                            rem_d[i] = rem_q[i] - CNT_W'(1);
                            idx_d[i] = idx_q[i] + CNT_W'(1);
                        end
                    end
                end
                // Finish decision is taken on the issuing cycle so done lands right after it.
                if ((req & ~(grant & last)) == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (wcnt_d >= BUDGET) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    trunc_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_HEADER;
            rem_d   = nentries;
            idx_d   = '0;
            bx_d    = rd_bx;
            wcnt_d  = '0;
            done_d  = 1'b0;
            trunc_d = 1'b0;
            rd_en   = '0;
            rd_add  = '0;
            sel_pre = SEL_IDLE;
            bx_pre  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            bx_q    <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            bx_q    <= bx_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
            pipe_q[0] <= {sel_pre, bx_pre};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign sel_out   = pipe_q[RD_LAT-1][6:3];
    assign bx_out    = pipe_q[RD_LAT-1][2:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign truncated = trunc_q;

endmodule

`default_nettype wire
